// File: rtl/pc_fetch_unit.sv
// Program-counter stage of the single-cycle MIPS core: next-PC selection, syscall halt FSM,
// retired-instruction counter. Optional redirect trace buffer enabled by macro PC_TRACE_EN.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter int          TRACE_DEPTH = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            stall,
   input  logic [1:0]                      pcJumpMode,
   input  logic [31:0]                     jumpInput,
   input  logic                            aluZero,
   input  logic                            haltRequest,
   input  logic [$clog2(TRACE_DEPTH)-1:0]  traceIndex,
   output logic [31:0]                     pc,
   output logic [31:0]                     pcNext,
   output logic                            halted,
   output logic                            misaligned,
   output logic [31:0]                     instret,
   output logic [31:0]                     traceData,
   output logic [$clog2(TRACE_DEPTH):0]    traceCount
);

   localparam int TW = $clog2(TRACE_DEPTH);

   localparam logic [1:0] MODE_NEXT   = 2'd0;
   localparam logic [1:0] MODE_BEQ    = 2'd1;
   localparam logic [1:0] MODE_ABS    = 2'd2;
   localparam logic [1:0] MODE_ABSREG = 2'd3;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] r_instret;
   logic        r_misaligned;
   logic [31:0] w_pc4;
   logic [31:0] w_pc_next;
   logic        w_retire;
   logic        w_load_pc;
   logic        w_redirect;
   logic        w_misaligned_set;

   assign w_pc4 = r_pc + 32'd4;

   // Next-PC selection; evaluated every cycle, including during stall and halt.
   always_comb begin
      w_pc_next = w_pc4;
      case (pcJumpMode)
         MODE_NEXT: begin
            w_pc_next = w_pc4;
         end
         MODE_BEQ: begin
            if (aluZero) begin
               w_pc_next = w_pc4 + (jumpInput << 2);
            end else begin
               w_pc_next = w_pc4;
            end
         end
         MODE_ABS: begin
            w_pc_next = {w_pc4[31:28], jumpInput[25:0], 2'b00};
         end
         MODE_ABSREG: begin
            w_pc_next = {jumpInput[31:2], 2'b00};
         end
         default: begin
            w_pc_next = w_pc4;
         end
      endcase
   end

   // The syscall retires but leaves the PC where it is.
   assign w_retire         = (r_state == ST_RUN) && !stall;
   assign w_load_pc        = w_retire && !haltRequest;
   assign w_redirect       = w_retire &&
                             ((pcJumpMode == MODE_ABS) || (pcJumpMode == MODE_ABSREG) ||
                              ((pcJumpMode == MODE_BEQ) && aluZero));
   assign w_misaligned_set = w_retire && (pcJumpMode == MODE_ABSREG) &&
                             (jumpInput[1:0] != 2'b00);

   // Halt FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Halt FSM next state: only reset leaves HALT.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_retire && haltRequest) begin
               w_state_next = ST_HALT;
            end else begin
               w_state_next = ST_RUN;
            end
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   // Architectural PC, retire counter and sticky misalignment flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_instret    <= 32'd0;
         r_misaligned <= 1'b0;
      end else begin
         if (w_load_pc) begin
            r_pc <= w_pc_next;
         end else begin
            r_pc <= r_pc;
         end
         if (w_retire) begin
            r_instret <= r_instret + 32'd1;
         end else begin
            r_instret <= r_instret;
         end
         r_misaligned <= r_misaligned | w_misaligned_set;
      end
   end

   assign pc         = r_pc;
   assign pcNext     = w_pc_next;
   assign halted     = (r_state == ST_HALT);
   assign misaligned = r_misaligned;
   assign instret    = r_instret;

`ifdef PC_TRACE_EN
   logic [31:0]   r_trace_mem [TRACE_DEPTH];
   logic [TW-1:0] r_wr_ptr;
   logic [TW:0]   r_trace_count;
   logic [TW-1:0] w_rd_ptr;

   // Circular redirect log; the write pointer wraps naturally at TRACE_DEPTH.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < TRACE_DEPTH; i++) begin
            r_trace_mem[i] <= 32'd0;
         end
         r_wr_ptr      <= '0;
         r_trace_count <= '0;
      end else if (w_redirect) begin
         r_trace_mem[r_wr_ptr] <= w_pc_next;
         r_wr_ptr              <= r_wr_ptr + TW'(1);
         if (r_trace_count < (TW+1)'(TRACE_DEPTH)) begin
            r_trace_count <= r_trace_count + (TW+1)'(1);
         end else begin
            r_trace_count <= r_trace_count;
         end
      end else begin
         r_wr_ptr      <= r_wr_ptr;
         r_trace_count <= r_trace_count;
      end
   end

   assign w_rd_ptr = r_wr_ptr - TW'(1) - traceIndex;

   // Index 0 is the newest entry; indices past the valid count read as zero.
   always_comb begin
      traceData = 32'd0;
      if ({1'b0, traceIndex} < r_trace_count) begin
         traceData = r_trace_mem[w_rd_ptr];
      end else begin
         traceData = 32'd0;
      end
   end

   assign traceCount = r_trace_count;
`else
   logic w_unused_trace;
   assign w_unused_trace = w_redirect ^ (^traceIndex);
   assign traceData      = 32'd0;
   assign traceCount     = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; trace expectations follow PC_TRACE_EN.
module tb_pc_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  pcJumpMode;
   logic [31:0] jumpInput;
   logic        aluZero;
   logic        haltRequest;
   logic [2:0]  traceIndex;
   logic [31:0] pc;
   logic [31:0] pcNext;
   logic        halted;
   logic        misaligned;
   logic [31:0] instret;
   logic [31:0] traceData;
   logic [3:0]  traceCount;

   int tests = 0;
   int fails = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_3000), .TRACE_DEPTH(8)) dut (
      .clock(clock), .reset(reset), .stall(stall), .pcJumpMode(pcJumpMode),
      .jumpInput(jumpInput), .aluZero(aluZero), .haltRequest(haltRequest),
      .traceIndex(traceIndex), .pc(pc), .pcNext(pcNext), .halted(halted),
      .misaligned(misaligned), .instret(instret), .traceData(traceData),
      .traceCount(traceCount)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; pcJumpMode = 2'd0; jumpInput = 32'd0;
      aluZero = 1'b0; haltRequest = 1'b0; traceIndex = 3'd0;
      step(); step();
      check("rst_pc", pc, 32'h3000);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_tcount", {28'd0, traceCount}, 32'd0);
      check("rst_tdata", traceData, 32'd0);

      reset = 1'b0;
      step(); check("seq_pc1", pc, 32'h3004);
      step(); check("seq_pc2", pc, 32'h3008);
      step(); check("seq_pc3", pc, 32'h300C);
      check("seq_instret", instret, 32'd3);
      step(); check("seq_pc4", pc, 32'h3010);

      pcJumpMode = 2'd1; jumpInput = 32'hFFFF_FFFF; aluZero = 1'b1;
      #1 check("beq_taken_next", pcNext, 32'h3010);
      step(); check("beq_taken_pc", pc, 32'h3010);
      check("beq_instret", instret, 32'd5);
      aluZero = 1'b0;
      #1 check("beq_not_next", pcNext, 32'h3014);
      step(); check("beq_not_pc", pc, 32'h3014);

      reset = 1'b1; pcJumpMode = 2'd0;
      step(); reset = 1'b0;
      check("rst2_pc", pc, 32'h3000);
      check("rst2_instret", instret, 32'd0);
      pcJumpMode = 2'd2; jumpInput = 32'h0000_0C10;
      #1 check("abs_next", pcNext, 32'h3040);
      step(); check("abs_pc", pc, 32'h3040);
      check("abs_mis", {31'd0, misaligned}, 32'd0);
      pcJumpMode = 2'd3; jumpInput = 32'h0000_3006;
      step(); check("absreg_pc", pc, 32'h3004);
      check("absreg_mis", {31'd0, misaligned}, 32'd1);
`ifdef PC_TRACE_EN
      check("tr2_count", {28'd0, traceCount}, 32'd2);
      traceIndex = 3'd0; #1 check("tr2_idx0", traceData, 32'h3004);
      traceIndex = 3'd1; #1 check("tr2_idx1", traceData, 32'h3040);
      traceIndex = 3'd2; #1 check("tr2_idx2_empty", traceData, 32'd0);
`else
      check("tr2_count_off", {28'd0, traceCount}, 32'd0);
      traceIndex = 3'd1; #1 check("tr2_data_off", traceData, 32'd0);
`endif
      pcJumpMode = 2'd0; jumpInput = 32'd0;
      step(); step();
      check("mis_sticky_pc", pc, 32'h300C);
      check("mis_sticky", {31'd0, misaligned}, 32'd1);
      check("mis_instret", instret, 32'd4);

      stall = 1'b1; haltRequest = 1'b1;
      step(); step();
      check("stall_pc", pc, 32'h300C);
      check("stall_halted", {31'd0, halted}, 32'd0);
      check("stall_instret", instret, 32'd4);
      stall = 1'b0;
      step();
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_pc", pc, 32'h300C);
      check("halt_instret", instret, 32'd5);
      haltRequest = 1'b0; pcJumpMode = 2'd2; jumpInput = 32'h0000_0055;
      for (int i = 0; i < 10; i++) begin
         stall = i[0];
         step();
      end
      check("frozen_pc", pc, 32'h300C);
      check("frozen_instret", instret, 32'd5);
      check("frozen_halted", {31'd0, halted}, 32'd1);
      check("halt_pcnext", pcNext, 32'h0000_0154);
`ifdef PC_TRACE_EN
      check("frozen_tcount", {28'd0, traceCount}, 32'd2);
`endif
      reset = 1'b1; stall = 1'b0;
      step(); reset = 1'b0;
      check("unhalt_pc", pc, 32'h3000);
      check("unhalt_halted", {31'd0, halted}, 32'd0);
      check("unhalt_mis", {31'd0, misaligned}, 32'd0);

      // Ten abs redirects to T_k = 0x400 + 16*k.
      pcJumpMode = 2'd2;
      for (int k = 0; k < 10; k++) begin
         jumpInput = 32'h100 + 32'(4 * k);
         step();
      end
      check("tr_pc", pc, 32'h490);
      check("tr_instret", instret, 32'd10);
      pcJumpMode = 2'd0; stall = 1'b1;
`ifdef PC_TRACE_EN
      check("tr_count", {28'd0, traceCount}, 32'd8);
      traceIndex = 3'd0; #1 check("tr_idx0", traceData, 32'h490);
      traceIndex = 3'd7; #1 check("tr_idx7", traceData, 32'h420);
      traceIndex = 3'd3; #1 check("tr_idx3", traceData, 32'h460);
`else
      check("tr_count_off", {28'd0, traceCount}, 32'd0);
      traceIndex = 3'd0; #1 check("tr_data_off", traceData, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter stage of the single-cycle MIPS core. It holds the architectural PC and drives the instruction-memory address. Each cycle it computes the next PC from the jump mode and jump operand produced by the controller/datapath for the current instruction. It also provides syscall halt control, a retired-instruction counter, and an optional redirect trace buffer.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset (word-aligned).
- TRACE_DEPTH, 8, number of trace entries; must be a power of two, 2–64.

Ports (clock, reset, inputs, outputs):
- clock  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high.
- stall  in  1  Hold the PC and do not retire the current instruction.
- pcJumpMode  in  2  Next-PC mode: 0 = next, 1 = beq, 2 = abs, 3 = absreg.
- jumpInput  in  32  Operand selected by the datapath for the current jump mode:
  - beq: sign-extended imm16.
  - abs: imm26, zero-extended.
  - absreg: GPR value.
- aluZero  in  1  ALU result is zero; used only in beq mode.
- haltRequest  in  1  Current instruction is a syscall.
- traceIndex  in  log2(TRACE_DEPTH)  Trace read index; 0 is the most recent entry.
- pc  out  32  Current PC; this is the instruction-memory address.
- pcNext  out  32  Combinational next PC.
- halted  out  1  High while the FSM is in HALT.
- misaligned  out  1  Sticky flag; set by an absreg target with bits [1:0] != 0.
- instret  out  32  Count of retired instructions.
- traceData  out  32  Target stored at traceIndex.
- traceCount  out  log2(TRACE_DEPTH)+1  Number of valid trace entries; saturates at TRACE_DEPTH.

## Operation
Next-PC arithmetic (all 32-bit, modulo 2^32), with pc4 = pc + 4:
- next: pc4.
- beq: pc4 + (jumpInput << 2) if aluZero, else pc4.
- abs: {pc4[31:28], jumpInput[25:0], 2'b00}.
- absreg: {jumpInput[31:2], 2'b00}. If jumpInput[1:0] != 0, misaligned is set at the update edge.

Halt FSM:
- Two states, RUN and HALT. Reset enters RUN.
- RUN, retire (that is, !stall) with haltRequest high: go to HALT. The syscall itself retires, and the PC does not advance.
- HALT: PC, instret and trace are frozen and all inputs are ignored. Only reset exits HALT.

Retirement:
- retire = RUN && !stall.
- On retire that is not a syscall: pc <= pcNext and instret += 1. instret wraps from 0xFFFF_FFFF to 0.
- stall takes precedence: a haltRequest during stall is ignored and the PC holds.

Redirects:
- A redirect is a retire where the mode is abs, absreg, or beq with aluZero.
- Every redirect, including one whose target equals pc4, is logged.
- pcNext is still computed during stall and halt; it is observable but not loaded.

## Timing
- pcNext is combinational from pc and the inputs, with zero latency.
- pc, halted, instret, misaligned and the trace update only on the rising clock edge.
- Reset values: pc = RESET_PC, halted = 0, misaligned = 0, instret = 0, traceCount = 0, traceData = 0.
- Reset asserted mid-operation, including in HALT, overrides everything on that edge.
- One instruction retires per cycle when not stalled.

## Configuration
Macro PC_TRACE_EN.
- Defined:
  - Implement a circular buffer of TRACE_DEPTH × 32 bits holding redirect targets. Each redirect overwrites the oldest entry.
  - traceData = entry written traceIndex redirects ago. An index at or above traceCount returns 0.
  - traceCount increments on each redirect and saturates at TRACE_DEPTH. The write pointer wraps modulo TRACE_DEPTH.
- Undefined:
  - No buffer storage is built.
  - traceData and traceCount are tied to 0, and traceIndex is unused.

## Test plan
- Reset then sequential flow: release reset with mode = 0 for 3 cycles -> pc = 0x3000, then 0x3004, 0x3008, 0x300C; instret = 3.
- beq: at pc = 0x3010, mode = 1, jumpInput = 0xFFFF_FFFF, aluZero = 1 -> pc stays 0x3010. Same with aluZero = 0 -> pc = 0x3014.
- abs and absreg:
  - mode = 2, jumpInput = 0x0000_0C10 at pc = 0x3000 -> pc = 0x0000_3040.
  - Then mode = 3, jumpInput = 0x0000_3006 -> pc = 0x3004 and misaligned = 1, staying 1 until reset.
- Halt and stall:
  - haltRequest together with stall for 2 cycles -> PC held, halted = 0.
  - Deassert stall -> halted = 1 at the next edge; pc and instret frozen for 10 cycles.
  - Assert reset -> pc = 0x3000, halted = 0.
- Trace (PC_TRACE_EN defined, TRACE_DEPTH = 8): issue 10 abs redirects to targets T0..T9 ->
  - traceCount = 8.
  - traceIndex 0 -> T9, traceIndex 7 -> T2.
  - With the macro undefined, traceData = 0 and traceCount = 0.
